// File: rtl/step.sv
`timescale 1ns/1ps
// Free-running micro-step counter (0..STEPS-1) for the tiny16 control decoder, plus one-hot/first/last decodes.
// Latency: counter registered, decodes combinational from it. Backpressure: none, counts every edge.
module step #(
  parameter int STEPS = 8,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CW-1:0]    counter,
  output logic [STEPS-1:0] step_onehot,
  output logic             first,
  output logic             last
);

  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  // Any value at or above the last step (including unreachable codes) loads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
    end else if (counter >= LAST_STEP) begin
      counter <= '0;
    end else begin
      counter <= counter + CW'(1);
    end
  end

  always_comb begin
    step_onehot = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (counter == CW'(i)) begin
        step_onehot[i] = 1'b1;
      end
    end
  end

  assign first = (counter == '0);
  assign last  = (counter == LAST_STEP);

endmodule

// File: tb/tb_step.sv
`timescale 1ns/1ps
// Scoreboarded bench for step: STEPS=8 and STEPS=5 instances share clock and reset.
module tb_step;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] c8, c5;
  logic [7:0] oh8;
  logic [4:0] oh5;
  logic       f8, l8, f5, l5;

  step #(.STEPS(8), .CW(3)) dut8 (
    .clk(clk), .rst(rst), .counter(c8), .step_onehot(oh8), .first(f8), .last(l8)
  );

  step #(.STEPS(5), .CW(3)) dut5 (
    .clk(clk), .rst(rst), .counter(c5), .step_onehot(oh5), .first(f5), .last(l5)
  );

  // Rising edges at t = 1, 3, 5, ... ns; falling edges at even ns are the sample points.
  always #1 clk = ~clk;

  typedef struct {
    int    c8;
    int    c5;
    string tag;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   base     = 0;
  int   tests    = 0;
  int   fails    = 0;
  bit   chk_en   = 1'b0;

  // Reference: expected step is the number of unreset edges since the last reset, modulo STEPS.
  always @(posedge clk) if (!rst) edge_cnt++;

  function automatic exp_t model(string tag);
    exp_t e;
    e.c8  = (edge_cnt - base) % 8;
    e.c5  = (edge_cnt - base) % 5;
    e.tag = tag;
    return e;
  endfunction

  always @(negedge clk) if (chk_en) q.push_back(model("run"));

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare(exp_t e);
    chk({e.tag, ".cnt8"},    int'(c8),          e.c8);
    chk({e.tag, ".onehot8"}, int'(oh8),         1 << e.c8);
    chk({e.tag, ".ones8"},   $countones(oh8),   1);
    chk({e.tag, ".first8"},  int'(f8),          (e.c8 == 0) ? 1 : 0);
    chk({e.tag, ".last8"},   int'(l8),          (e.c8 == 7) ? 1 : 0);
    chk({e.tag, ".cnt5"},    int'(c5),          e.c5);
    chk({e.tag, ".onehot5"}, int'(oh5),         1 << e.c5);
    chk({e.tag, ".first5"},  int'(f5),          (e.c5 == 0) ? 1 : 0);
    chk({e.tag, ".last5"},   int'(l5),          (e.c5 == 4) ? 1 : 0);
  endtask

  // Monitor: pops and checks every expectation as soon as it appears.
  initial begin
    exp_t e;
    forever begin
      #0.05;
      while (q.size() > 0) begin
        e = q.pop_front();
        compare(e);
      end
    end
  end

  // Called just after a falling edge; rst rises and falls strictly between edges.
  task automatic pulse(int k);
    rst  = 1'b1;
    base = edge_cnt;
    #0.1;
    q.push_back(model("async_rst"));
    repeat (k) #2;
    #1.1;
    rst = 1'b0;
  endtask

  initial begin
    #4;
    rst  = 1'b1;
    base = edge_cnt;
    #0.1;
    q.push_back(model("async_rst"));
    chk_en = 1'b1;
    #1.9;
    rst = 1'b0;

    // Count, wrap and decode consistency over free-running cycles.
    repeat (28) @(negedge clk);

    // Reset from step 5 of the 8-step instance.
    do @(negedge clk); while (((edge_cnt - base) % 8) != 5);
    #0.3;
    pulse(0);
    repeat (3) @(negedge clk);

    repeat (15) begin
      repeat ($urandom_range(1, 12)) @(negedge clk);
      #0.3;
      pulse(int'($urandom_range(0, 2)));
    end

    repeat (10) @(negedge clk);
    #0.5;
    chk_en = 1'b0;
    #0.5;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
